// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
// Holds the fetch state encoding, the instruction/PC width, the PC step and
// the instruction word that marks end of program.
package fetch_pkg;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_t;

  localparam int          INSTR_W = 32;
  localparam logic [31:0] PC_STEP = 32'd4;
  localparam logic [31:0] NOP_END = 32'h0000_0000;

endpackage

// File: rtl/instruction_fetch_if.sv
// Bundle of the fetch stage's pipeline-facing signals.
// master: the fetch stage (drives PC, IF/ID slot, status; samples stall,
//         redirect and memory return).
// slave : the environment (hazard unit, execute stage, instruction memory,
//         decode stage).
interface instruction_fetch_if #(
  parameter int CNT_W = 16
);
  logic              stall;
  logic              branchTaken;
  logic [31:0]       branchTarget;
  logic [31:0]       instruction;
  logic              fimDoArquivo;
  logic [31:0]       pcOut;
  logic [31:0]       ifIdInstruction;
  logic [31:0]       ifIdPc;
  logic              ifIdValid;
  logic              halted;
  logic              misaligned;
  logic [CNT_W-1:0]  fetchCount;

  modport master (
    input  stall, branchTaken, branchTarget, instruction, fimDoArquivo,
    output pcOut, ifIdInstruction, ifIdPc, ifIdValid, halted, misaligned,
           fetchCount
  );

  modport slave (
    output stall, branchTaken, branchTarget, instruction, fimDoArquivo,
    input  pcOut, ifIdInstruction, ifIdPc, ifIdValid, halted, misaligned,
           fetchCount
  );
endinterface

// File: rtl/instruction_fetch_if_id_reg.sv
// IF/ID pipeline register.
// Ports: clock, reset (sync, active-high); load captures instr_in/pc_in and
// sets valid; flush clears valid only (data held); with neither asserted the
// register holds (stall / halted). flush wins over load.
module if_id_reg
  import fetch_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic               flush,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [31:0]        pc_in,
  output logic [INSTR_W-1:0] instr_out,
  output logic [31:0]        pc_out,
  output logic               valid
);

  always_ff @(posedge clock) begin
    if (reset) begin
      instr_out <= '0;
      pc_out    <= '0;
      valid     <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      instr_out <= instr_in;
      pc_out    <= pc_in;
      valid     <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage.
// Owns the PC (drives the memory read address), the RUN/HALTED state, the
// sticky misaligned-redirect flag and the saturating fetched-instruction
// counter; the IF/ID slot lives in if_id_reg.
// Ports: clock, reset (sync, active-high), bus (instruction_fetch_if.master).
//
// state     | meaning
// ST_RUN    | fetching; PC advances unless redirected, stalled or at end
// ST_HALTED | end of program seen; only a redirect restarts fetching
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic                clock,
  input  logic                reset,
  instruction_fetch_if.master bus
);

  fetch_state_t     state;
  logic [31:0]      pc;
  logic             misaligned;
  logic [CNT_W-1:0] fetch_count;

  logic eop;
  logic running;
  logic capture;
  logic flush;

  // Memory returns zero past the last program line, so a zero word also ends.
  assign eop     = bus.fimDoArquivo | (bus.instruction == NOP_END);
  assign running = (state == ST_RUN);
  assign capture = running & ~bus.branchTaken & ~bus.stall & ~eop;
  // Redirect drops the wrong-path word; reaching end drops the end word.
  assign flush   = bus.branchTaken | (running & ~bus.stall & eop);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_RUN;
      pc          <= RESET_PC;
      misaligned  <= 1'b0;
      fetch_count <= '0;
    end else if (bus.branchTaken) begin
      state <= ST_RUN;
      pc    <= {bus.branchTarget[31:2], 2'b00};
      if (bus.branchTarget[1:0] != 2'b00) begin
        misaligned <= 1'b1;
      end
    end else if (running && !bus.stall) begin
      if (eop) begin
        state <= ST_HALTED;
      end else begin
        pc <= pc + PC_STEP;
        if (fetch_count != {CNT_W{1'b1}}) begin
          fetch_count <= fetch_count + CNT_W'(1);
        end
      end
    end
  end

  if_id_reg u_if_id_reg (
    .clock     (clock),
    .reset     (reset),
    .load      (capture),
    .flush     (flush),
    .instr_in  (bus.instruction),
    .pc_in     (pc),
    .instr_out (bus.ifIdInstruction),
    .pc_out    (bus.ifIdPc),
    .valid     (bus.ifIdValid)
  );

  assign bus.pcOut      = pc;
  assign bus.halted     = (state == ST_HALTED);
  assign bus.misaligned = misaligned;
  assign bus.fetchCount = fetch_count;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  instruction_fetch_if #(.CNT_W(16)) bus1 ();
  instruction_fetch_if #(.CNT_W(4))  bus2 ();

  instruction_fetch #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFF8), .CNT_W(4)) dut2 (
    .clock (clock),
    .reset (reset),
    .bus   (bus2)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        valid;
    logic        halted;
    logic        mis;
    int          cnt;
    int          cnt_max;
    logic [31:0] reset_pc;
  } model_t;

  model_t m1, m2;
  int checks = 0;
  int errors = 0;
  logic [31:0] mem [64];

  function automatic logic [31:0] imem(input logic [31:0] a);
    if (a < 32'd256) return mem[a[7:2]];
    return a ^ 32'h1357_0001;
  endfunction

  // Reference: what the fetch stage should look like after one clock edge.
  function automatic model_t step(input model_t m, input logic rst, st, br,
                                  input logic [31:0] tgt, input logic fim,
                                  input logic [31:0] instr);
    model_t n = m;
    if (rst) begin
      n.pc = m.reset_pc; n.id_instr = 0; n.id_pc = 0; n.valid = 0;
      n.halted = 0; n.mis = 0; n.cnt = 0;
    end else if (br) begin
      n.pc = tgt & 32'hFFFF_FFFC;
      n.valid = 0;
      n.halted = 0;
      if (tgt % 4 != 0) n.mis = 1;
    end else if (m.halted || st) begin
      // nothing moves
    end else if (fim || instr == 0) begin
      n.halted = 1;
      n.valid = 0;
    end else begin
      n.id_instr = instr;
      n.id_pc = m.pc;
      n.valid = 1;
      n.pc = m.pc + 4;
      if (m.cnt < m.cnt_max) n.cnt = m.cnt + 1;
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_dut1();
    check("d1_pcOut",   bus1.pcOut,               m1.pc);
    check("d1_ifInstr", bus1.ifIdInstruction,     m1.id_instr);
    check("d1_ifPc",    bus1.ifIdPc,              m1.id_pc);
    check("d1_valid",   32'(bus1.ifIdValid),      32'(m1.valid));
    check("d1_halted",  32'(bus1.halted),         32'(m1.halted));
    check("d1_misal",   32'(bus1.misaligned),     32'(m1.mis));
    check("d1_count",   32'(bus1.fetchCount),     32'(m1.cnt));
  endtask

  task automatic check_dut2();
    check("d2_pcOut",   bus2.pcOut,               m2.pc);
    check("d2_ifInstr", bus2.ifIdInstruction,     m2.id_instr);
    check("d2_ifPc",    bus2.ifIdPc,              m2.id_pc);
    check("d2_valid",   32'(bus2.ifIdValid),      32'(m2.valid));
    check("d2_halted",  32'(bus2.halted),         32'(m2.halted));
    check("d2_count",   32'(bus2.fetchCount),     32'(m2.cnt));
  endtask

  // dut1 gets the directed/random stimulus; dut2 free-runs from its wrap-around
  // reset PC so the PC wrap and the 4-bit counter saturation are exercised.
  task automatic cycle(input logic rst, st, br, input logic [31:0] tgt,
                       input logic fim, zero);
    logic [31:0] i1, i2;
    @(negedge clock);
    i1 = zero ? 32'h0 : imem(m1.pc);
    i2 = imem(m2.pc);
    reset = rst;
    bus1.stall = st; bus1.branchTaken = br; bus1.branchTarget = tgt;
    bus1.fimDoArquivo = fim; bus1.instruction = i1;
    bus2.stall = 1'b0; bus2.branchTaken = 1'b0; bus2.branchTarget = 32'h0;
    bus2.fimDoArquivo = 1'b0; bus2.instruction = i2;
    @(posedge clock);
    m1 = step(m1, rst, st, br, tgt, fim, i1);
    m2 = step(m2, rst, 1'b0, 1'b0, 32'h0, 1'b0, i2);
    #1;
    check_dut1();
    check_dut2();
  endtask

  initial begin
    reset = 1'b1;
    bus1.stall = 0; bus1.branchTaken = 0; bus1.branchTarget = 0;
    bus1.fimDoArquivo = 0; bus1.instruction = 0;
    bus2.stall = 0; bus2.branchTaken = 0; bus2.branchTarget = 0;
    bus2.fimDoArquivo = 0; bus2.instruction = 0;
    for (int i = 0; i < 64; i++) mem[i] = $urandom() | 32'h1;
    mem[0] = 32'h00500093;
    mem[1] = 32'h00a00113;
    mem[2] = 32'h002081b3;
    m1 = '{default: 0}; m1.cnt_max = 65535; m1.reset_pc = 32'h0000_0000;
    m2 = '{default: 0}; m2.cnt_max = 15;    m2.reset_pc = 32'hFFFF_FFF8;

    cycle(1, 0, 0, 0, 0, 0);
    check("reset_pc_const", bus1.pcOut, 32'h0);
    check("reset_pc2_const", bus2.pcOut, 32'hFFFF_FFF8);

    // three straight fetches
    cycle(0, 0, 0, 0, 0, 0);
    check("wrap_fffc", bus2.pcOut, 32'hFFFF_FFFC);
    cycle(0, 0, 0, 0, 0, 0);
    check("wrap_zero", bus2.pcOut, 32'h0);
    cycle(0, 0, 0, 0, 0, 0);
    check("count3", 32'(bus1.fetchCount), 32'd3);

    // stall two cycles, then release
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    check("stall_pc_hold", bus1.pcOut, 32'd12);
    // branch beats a concurrent stall
    cycle(0, 1, 1, 32'h40, 0, 0);
    check("branch_pc", bus1.pcOut, 32'h40);
    cycle(0, 0, 0, 0, 0, 0);
    check("target_captured_pc", bus1.ifIdPc, 32'h40);

    // go to 16 and signal end of program
    cycle(0, 0, 1, 32'h10, 0, 0);
    cycle(0, 0, 0, 0, 1, 0);
    check("halt_flag", 32'(bus1.halted), 32'd1);
    cycle(0, 1, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 0);
    check("halt_pc_hold", bus1.pcOut, 32'd16);
    cycle(0, 0, 1, 32'h4, 0, 0);
    check("resume_pc", bus1.pcOut, 32'h4);
    cycle(0, 0, 0, 0, 0, 0);

    // misaligned redirect, sticky across fetches
    cycle(0, 0, 1, 32'h22, 0, 0);
    check("misal_pc", bus1.pcOut, 32'h20);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0);
    check("misal_sticky", 32'(bus1.misaligned), 32'd1);

    // end via a zero instruction word, then escape
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 1, 32'h8, 0, 0);

    // random mix
    for (int i = 0; i < 300; i++) begin
      logic [31:0] t;
      t = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) t = t & 32'hFFFF_FFFC;
      cycle(0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, t,
            $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0);
    end

    // reset mid-stream overrides a simultaneous branch
    cycle(1, 0, 1, 32'h80, 0, 0);
    check("midreset_pc", bus1.pcOut, 32'h0);
    check("midreset_misal", 32'(bus1.misaligned), 32'd0);
    cycle(0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
